// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I-subset core: FETCH, DECODE, EXEC, MEM, WB, HALT.
// Optional macro CTRL_PERF_CNT_EN adds retired-instruction and cycle counters.
module multicycle_ctrl #(
  parameter int XLEN      = 32,
  parameter int IMM_SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      instr,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 branch_taken,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic [IMM_SEL_W-1:0] imm_sel,
  output logic                 alu_src,
  output logic [3:0]           alu_op,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 dmem_re,
  output logic                 dmem_we,
  output logic                 halted,
  output logic                 illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]          retired_cnt,
  output logic [31:0]          cycle_cnt
`endif
);

  localparam logic [IMM_SEL_W-1:0] IMM_I = 'd0;
  localparam logic [IMM_SEL_W-1:0] IMM_S = 'd1;
  localparam logic [IMM_SEL_W-1:0] IMM_B = 'd2;
  localparam logic [IMM_SEL_W-1:0] IMM_U = 'd3;
  localparam logic [IMM_SEL_W-1:0] IMM_J = 'd4;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLL   = 4'd6;
  localparam logic [3:0] ALU_SRL   = 4'd7;
  localparam logic [3:0] ALU_PASSB = 4'd8;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_SYSTEM, C_ILLEGAL} class_t;

  state_t          state, state_n;
  class_t          cls;
  logic [XLEN-1:0] ir;
  logic [2:0]      funct3;
  logic [3:0]      f3_op;
  logic            illegal_q;
  logic            set_illegal;
  logic            unused_ir;

  assign funct3    = ir[14:12];
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  // Decode is purely a function of IR, so it holds steady from DECODE until the next fetch latches.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a missed branch otherwise infers a latch.
    cls     = C_ILLEGAL;
    imm_sel = IMM_I;
    alu_src = 1'b0;
    alu_op  = ALU_ADD;
    f3_op   = ALU_ADD;
    case (funct3)
      3'b001:         f3_op = ALU_SLL;
      3'b010, 3'b011: f3_op = ALU_SLT;
      3'b100:         f3_op = ALU_XOR;
      3'b101:         f3_op = ALU_SRL;
      3'b110:         f3_op = ALU_OR;
      3'b111:         f3_op = ALU_AND;
      default:        f3_op = ALU_ADD;
    endcase
    case (ir[6:0])
      OPC_OP: begin
        cls    = C_ALU;
        alu_op = (funct3 == 3'b000 && ir[30]) ? ALU_SUB : f3_op;
      end
      OPC_OPIMM: begin
        cls     = C_ALU;
        alu_src = 1'b1;
        alu_op  = f3_op;
      end
      OPC_LUI: begin
        cls     = C_ALU;
        imm_sel = IMM_U;
        alu_src = 1'b1;
        alu_op  = ALU_PASSB;
      end
      OPC_LOAD: begin
        cls     = C_LOAD;
        alu_src = 1'b1;
      end
      OPC_STORE: begin
        cls     = C_STORE;
        imm_sel = IMM_S;
        alu_src = 1'b1;
      end
      OPC_BRANCH: begin
        cls     = C_BRANCH;
        imm_sel = IMM_B;
        alu_op  = ALU_SUB;
      end
      OPC_JAL: begin
        cls     = C_JAL;
        imm_sel = IMM_J;
      end
      OPC_SYSTEM: cls = C_SYSTEM;
      default:    cls = C_ILLEGAL;
    endcase
  end

  always_comb begin
    state_n     = state;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = 2'd0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    dmem_re     = 1'b0;
    dmem_we     = 1'b0;
    halted      = 1'b0;
    set_illegal = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls == C_SYSTEM || cls == C_ILLEGAL) begin
          set_illegal = (cls == C_ILLEGAL);
          state_n     = S_HALT;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_ALU:            state_n = S_WB;
          C_LOAD, C_STORE:  state_n = S_MEM;
          C_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ^ funct3[0];
            state_n = S_FETCH;
          end
          C_JAL: begin
            reg_we  = 1'b1;
            wb_sel  = 2'd2;
            pc_we   = 1'b1;
            pc_sel  = 1'b1;
            state_n = S_FETCH;
          end
          default:          state_n = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_re = (cls == C_LOAD);
        dmem_we = (cls != C_LOAD);
        if (dmem_ready) begin
          if (cls == C_LOAD) begin
            state_n = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_n = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        wb_sel  = (cls == C_LOAD) ? 2'd1 : 2'd0;
        state_n = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_n = S_FETCH;
    endcase
    // Reset overrides everything in the cycle it is sampled: no half-finished memory access or writeback.
    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      reg_we   = 1'b0;
      wb_sel   = 2'd0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      dmem_re  = 1'b0;
      dmem_we  = 1'b0;
      halted   = 1'b0;
    end
  end

  assign illegal = illegal_q && !rst;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= S_FETCH;
      // NOTE: IR is reset explicitly so the post-reset decode outputs come out as zero (IMM_I/ADD).
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_n;
      if (ir_we)       ir        <= instr;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      retired_cnt <= 32'd0;
    end else begin
      if (state != S_HALT) cycle_cnt   <= cycle_cnt + 32'd1;
      if (pc_we)           retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds a per-cycle expectation list from instruction-level rules,
// drives it cycle by cycle and compares every output each cycle.
module tb_multicycle_ctrl;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
  localparam logic [3:0] A_SLT = 4'd5, A_SLL = 4'd6, A_SRL = 4'd7, A_PASSB = 4'd8;
  // ALU op for funct3 = 0..7, nibble i holds the op for funct3 == i
  localparam logic [31:0] F3_OPS = {A_AND, A_OR, A_SRL, A_XOR, A_SLT, A_SLT, A_SLL, A_ADD};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;
  logic        imem_req, ir_we, alu_src, reg_we, pc_we, pc_sel, dmem_re, dmem_we, halted, illegal;
  logic [2:0]  imm_sel;
  logic [3:0]  alu_op;
  logic [1:0]  wb_sel;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt, cycle_cnt;
`endif

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .branch_taken(branch_taken), .imem_req(imem_req), .ir_we(ir_we), .imm_sel(imm_sel),
    .alu_src(alu_src), .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we),
    .pc_sel(pc_sel), .dmem_re(dmem_re), .dmem_we(dmem_we), .halted(halted), .illegal(illegal)
`ifdef CTRL_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef enum {K_ALU_R, K_ALU_I, K_LUI, K_LOAD, K_STORE, K_BR, K_JAL, K_SYS, K_ILL} kind_t;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        taken;
    logic [10:0] strb;
    logic        chk_dec;
    logic [7:0]  dec;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  bit   chk_en = 1'b0;
  int   cyc = 0;
  bit   noise = 1'b0;
  bit   just_reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic kind_t kind_of(input logic [31:0] w);
    case (w[6:0])
      7'h33:   return K_ALU_R;
      7'h13:   return K_ALU_I;
      7'h37:   return K_LUI;
      7'h03:   return K_LOAD;
      7'h23:   return K_STORE;
      7'h63:   return K_BR;
      7'h6F:   return K_JAL;
      7'h73:   return K_SYS;
      default: return K_ILL;
    endcase
  endfunction

  // {imm_sel, alu_src, alu_op} the instruction word requires
  function automatic logic [7:0] dec_of(input logic [31:0] w);
    logic [3:0] op;
    op = F3_OPS[w[14:12]*4 +: 4];
    case (kind_of(w))
      K_ALU_R: return {IMM_I, 1'b0, (w[14:12] == 3'd0 && w[30]) ? A_SUB : op};
      K_ALU_I: return {IMM_I, 1'b1, op};
      K_LUI:   return {IMM_U, 1'b1, A_PASSB};
      K_LOAD:  return {IMM_I, 1'b1, A_ADD};
      K_STORE: return {IMM_S, 1'b1, A_ADD};
      K_BR:    return {IMM_B, 1'b0, A_SUB};
      K_JAL:   return {IMM_J, 1'b0, A_ADD};
      default: return 8'h00;
    endcase
  endfunction

  // Pack in DUT order: imem_req, ir_we, reg_we, wb_sel, pc_we, pc_sel, dmem_re, dmem_we, halted, illegal
  function automatic logic [10:0] mk(input bit req, input bit irw, input bit rw, input logic [1:0] wb,
                                     input bit pw, input bit ps, input bit re, input bit we,
                                     input bit h, input bit il);
    return {req, irw, rw, wb, pw, ps, re, we, h, il};
  endfunction

  task automatic push(input logic r, input logic [31:0] w, input logic ir_rdy, input logic dm_rdy,
                      input logic tk, input logic [10:0] s, input logic cd, input logic [7:0] d);
    ent_t e;
    e.rst = r; e.instr = w; e.imem_ready = ir_rdy; e.dmem_ready = dm_rdy;
    e.taken = tk; e.strb = s; e.chk_dec = cd; e.dec = d;
    q.push_back(e);
  endtask

  task automatic add_reset(input int cycles);
    for (int i = 0; i < cycles; i++) push(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 11'h0, 1'b0, 8'h0);
    just_reset = 1'b1;
  endtask

  task automatic add_halt(input int cycles, input bit ill);
    for (int i = 0; i < cycles; i++)
      push(1'b0, 32'h0060_0613, 1'b1, 1'b1, 1'b1, mk(0,0,0,2'd0,0,0,0,0,1,ill), 1'b0, 8'h0);
  endtask

  // One instruction: fw fetch waits, dw memory waits, mem_rst = memory cycle index where rst hits (-1 none)
  task automatic add_instr(input logic [31:0] w, input int fw, input int dw, input bit tk,
                           input int mem_rst, output int cnt);
    int    n0;
    kind_t k;
    logic  [7:0] d;
    bit    rdy;
    n0 = q.size();
    k  = kind_of(w);
    d  = dec_of(w);
    for (int i = 0; i < fw; i++)
      push(1'b0, 32'hFFFF_FFFF, 1'b0, noise, 1'b0, mk(1,0,0,2'd0,0,0,0,0,0,0), just_reset, 8'h0);
    push(1'b0, w, 1'b1, noise, 1'b0, mk(1,1,0,2'd0,0,0,0,0,0,0), just_reset, 8'h0);
    just_reset = 1'b0;
    push(1'b0, 32'h0000_007F, noise, noise, 1'b0, 11'h0, 1'b1, d);
    if (k == K_SYS || k == K_ILL) begin
      cnt = q.size() - n0;
      return;
    end
    case (k)
      K_BR:    push(1'b0, 32'h0, noise, noise, tk, mk(0,0,0,2'd0,1,tk ^ w[12],0,0,0,0), 1'b1, d);
      K_JAL:   push(1'b0, 32'h0, noise, noise, tk, mk(0,0,1,2'd2,1,1,0,0,0,0), 1'b1, d);
      default: push(1'b0, 32'h0, noise, noise, tk, 11'h0, 1'b1, d);
    endcase
    if (k == K_LOAD || k == K_STORE) begin
      for (int i = 0; i <= dw; i++) begin
        if (i == mem_rst) begin
          push(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 11'h0, 1'b0, 8'h0);
          just_reset = 1'b1;
          cnt = q.size() - n0;
          return;
        end
        rdy = (i == dw);
        push(1'b0, 32'h0, noise, rdy, 1'b0,
             mk(0,0,0,2'd0, rdy && k == K_STORE, 0, k == K_LOAD, k == K_STORE, 0, 0), 1'b1, d);
      end
    end
    if (k != K_BR && k != K_JAL && k != K_STORE)
      push(1'b0, 32'h0, noise, noise, 1'b0,
           mk(0,0,1,(k == K_LOAD) ? 2'd1 : 2'd0,1,0,0,0,0,0), 1'b1, d);
    cnt = q.size() - n0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check($sformatf("c%0d_strobes", cyc),
            {imem_req, ir_we, reg_we, wb_sel, pc_we, pc_sel, dmem_re, dmem_we, halted, illegal},
            cur.strb);
      if (cur.chk_dec) check($sformatf("c%0d_decode", cyc), {imm_sel, alu_src, alu_op}, cur.dec);
    end
  end

  initial begin
    logic [31:0] alu_words [9];
    alu_words = '{32'h003100B3, 32'h403100B3, 32'h003170B3, 32'h003160B3, 32'h003140B3,
                  32'h003120B3, 32'h003110B3, 32'h003150B3, 32'h123453B7};

    check("model_dec_addi", {24'h0, dec_of(32'h00A00613)}, {24'h0, IMM_I, 1'b1, A_ADD});
    check("model_dec_beq",  {24'h0, dec_of(32'h00060C63)}, {24'h0, IMM_B, 1'b0, A_SUB});
    check("model_dec_jal",  {24'h0, dec_of(32'hFEDFF06F)}, {24'h0, IMM_J, 1'b0, A_ADD});

    add_reset(2);
    add_instr(32'h00A00613, 0, 0, 0, -1, n); check("len_addi", n, 4);
    noise = 1'b1;
    add_instr(32'h00A00613, 2, 0, 0, -1, n); check("len_addi_fwait2", n, 6);
    noise = 1'b0;
    add_instr(32'h00060C63, 0, 0, 1, -1, n); check("len_beq", n, 3);
    add_instr(32'h00060C63, 0, 0, 0, -1, n);
    add_instr(32'h00061C63, 0, 0, 1, -1, n);
    noise = 1'b1;
    add_instr(32'h00061C63, 1, 0, 0, -1, n);
    add_instr(32'hFEDFF06F, 0, 0, 0, -1, n); check("len_jal", n, 3);
    add_instr(32'h00002283, 0, 3, 0, -1, n); check("len_lw_wait3", n, 8);
    noise = 1'b0;
    add_instr(32'h00502223, 0, 1, 0, -1, n); check("len_sw_wait1", n, 5);
    add_instr(32'h00502223, 0, 0, 0, -1, n); check("len_sw", n, 4);
    foreach (alu_words[i]) add_instr(alu_words[i], 0, 0, 0, -1, n);
    add_instr(32'h00000013, 0, 0, 0, -1, n);
    add_instr(32'h00502223, 0, 3, 0, 1, n); check("len_sw_rst", n, 5);
    add_instr(32'h00A00613, 0, 0, 0, -1, n);
    add_instr(32'h00000073, 0, 0, 0, -1, n); check("len_ecall", n, 2);
    add_halt(4, 1'b0);
    add_reset(1);
    add_instr(32'h0000007F, 0, 0, 0, -1, n);
    add_halt(5, 1'b1);
    add_reset(1);
    add_instr(32'h00A00613, 0, 0, 0, -1, n);

    foreach (q[i]) begin
      @(posedge clk);
      #1;
      rst          = q[i].rst;
      instr        = q[i].instr;
      imem_ready   = q[i].imem_ready;
      dmem_ready   = q[i].dmem_ready;
      branch_taken = q[i].taken;
      cur          = q[i];
      cyc          = i;
      chk_en       = 1'b1;
    end
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
